// File: rtl/qsfp_led_responder_pkg.sv
// Shared constants and types for the QSFP LED responder.
// Blink support is enabled by defining QSFP_LED_BLINK_EN.
package qsfp_led_responder_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] CMDERR = 2'b01;

    localparam int NUM_LANES = 4;

    localparam int LINK0_LSB = 0;
    localparam int ACT0_LSB  = 4;
    localparam int LINK1_LSB = 8;
    localparam int ACT1_LSB  = 12;

    typedef logic [15:0] led_reg_t;
    typedef logic [NUM_LANES-1:0] lane_t;

    function automatic lane_t lane_field(
        input led_reg_t r,
        input int lsb
    );
        return r[lsb +: NUM_LANES];
    endfunction

endpackage

// File: rtl/qsfp_led_responder_if.sv
// Ctrlport request/response bundle with master and slave views.
// Blink support is enabled by defining QSFP_LED_BLINK_EN.
interface qsfp_led_responder_if;

    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_byte_en;
    logic        resp_ack;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr,
        output req_data, req_byte_en,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr,
        input  req_data, req_byte_en,
        output resp_ack, resp_status, resp_data
    );

endinterface

// File: rtl/qsfp_led_blinker.sv
// Per-lane activity FSM: once armed, a lane finishes its on-phase.
// Blink support is enabled by defining QSFP_LED_BLINK_EN.
module qsfp_led_blinker (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic blink_phase,
    output logic led
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    logic [0:0] state;
    logic       phase_q;
    logic       phase_fall;

    assign phase_fall = phase_q & ~blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase_q <= 1'b0;
        end else begin
            phase_q <= blink_phase;
            unique case (state)
                IDLE:
                    if (active) state <= ARMED;
                ARMED:
                    if (phase_fall && !active)
                        state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign led = (state == ARMED) & blink_phase;

endmodule

// File: rtl/qsfp_led_responder_regs.sv
// Ctrlport slave holding the 16-bit LED register.
// Blink support is enabled by defining QSFP_LED_BLINK_EN.
module qsfp_led_responder_regs
    import qsfp_led_responder_pkg::*;
#(
    parameter logic [19:0] LED_REGISTER_ADDRESS = 20'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qsfp_led_responder_if.slave  bus,
    output led_reg_t             led_reg
);

    logic        hit;
    logic        ack_q;
    logic [1:0]  status_q;
    logic [31:0] data_q;

    assign hit = (bus.req_addr == LED_REGISTER_ADDRESS)
               & (bus.req_wr | bus.req_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg  <= '0;
            ack_q    <= 1'b0;
            status_q <= OKAY;
            data_q   <= '0;
        end else begin
            ack_q    <= hit;
            status_q <= (hit && bus.req_wr && bus.req_rd)
                      ? CMDERR : OKAY;
            // Only a clean read returns the register.
            data_q   <= (hit && bus.req_rd && !bus.req_wr)
                      ? {16'b0, led_reg} : '0;
            if (hit && bus.req_wr) begin
                if (bus.req_byte_en[0])
                    led_reg[7:0] <= bus.req_data[7:0];
                if (bus.req_byte_en[1])
                    led_reg[15:8] <= bus.req_data[15:8];
            end
        end
    end

    assign bus.resp_ack    = ack_q;
    assign bus.resp_status = status_q;
    assign bus.resp_data   = data_q;

endmodule

// File: rtl/qsfp_led_responder.sv
// QSFP link/activity LED register on a ctrlport bus.
// Define QSFP_LED_BLINK_EN to blink activity LEDs.
module qsfp_led_responder
    import qsfp_led_responder_pkg::*;
#(
    parameter logic [19:0] LED_REGISTER_ADDRESS = 20'd0,
    parameter int BLINK_HALF_PERIOD = 12500000
) (
    input  logic        ctrlport_clk,
    input  logic        ctrlport_rst_n,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    input  logic [3:0]  s_ctrlport_req_byte_en,
    output logic        s_ctrlport_resp_ack,
    output logic [1:0]  s_ctrlport_resp_status,
    output logic [31:0] s_ctrlport_resp_data,
    output logic [3:0]  qsfp0_led_link,
    output logic [3:0]  qsfp0_led_active,
    output logic [3:0]  qsfp1_led_link,
    output logic [3:0]  qsfp1_led_active
);

    qsfp_led_responder_if bus ();

    led_reg_t   led_reg;
    logic [7:0] act_bits;
    logic [7:0] act_led;

    assign bus.req_wr      = s_ctrlport_req_wr;
    assign bus.req_rd      = s_ctrlport_req_rd;
    assign bus.req_addr    = s_ctrlport_req_addr;
    assign bus.req_data    = s_ctrlport_req_data;
    assign bus.req_byte_en = s_ctrlport_req_byte_en;

    assign s_ctrlport_resp_ack    = bus.resp_ack;
    assign s_ctrlport_resp_status = bus.resp_status;
    assign s_ctrlport_resp_data   = bus.resp_data;

    qsfp_led_responder_regs #(
        .LED_REGISTER_ADDRESS (LED_REGISTER_ADDRESS)
    ) u_regs (
        .clk     (ctrlport_clk),
        .rst_n   (ctrlport_rst_n),
        .bus     (bus),
        .led_reg (led_reg)
    );

    assign act_bits = {lane_field(led_reg, ACT1_LSB),
                       lane_field(led_reg, ACT0_LSB)};

`ifdef QSFP_LED_BLINK_EN
    localparam int PW = (BLINK_HALF_PERIOD > 1)
                      ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(BLINK_HALF_PERIOD - 1);

    logic [PW-1:0] prescaler;
    logic          blink_phase;

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
        end else if (prescaler == P_MAX) begin
            prescaler   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            prescaler   <= prescaler + 1'b1;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lane
        qsfp_led_blinker u_blink (
            .clk         (ctrlport_clk),
            .rst_n       (ctrlport_rst_n),
            .active      (act_bits[i]),
            .blink_phase (blink_phase),
            .led         (act_led[i])
        );
    end
`else
    assign act_led = act_bits;
`endif

    assign qsfp0_led_link   = lane_field(led_reg, LINK0_LSB);
    assign qsfp1_led_link   = lane_field(led_reg, LINK1_LSB);
    assign qsfp0_led_active = act_led[3:0];
    assign qsfp1_led_active = act_led[7:4];

endmodule
